// File: rtl/my_mem.sv
// -----------------------------------------------------------------------------
// my_mem: single-port synchronous scratch RAM, DEPTH x DATA_WIDTH data bits.
//
// Each stored word also holds one parity bit. The word is
// {~^data_in, data_in}, which gives odd parity over all DATA_WIDTH+1 bits.
// Reads are registered, so data appears one cycle after the read request.
//
// Optional feature (compile-time macro):
//   PARITY_CHECK_EN - when defined, the module adds the parity_err output and
//                     checks parity on every read. When it is undefined, the
//                     parity bit is still stored but is never checked.
//
// Ports:
//   clk         in   1           clock; all logic runs on the rising edge
//   rst         in   1           synchronous, active-high reset
//   write       in   1           write enable
//   read        in   1           read enable
//   address     in   ADDR_WIDTH  word address, shared by read and write
//   data_in     in   DATA_WIDTH  write data
//   data_out    out  DATA_WIDTH  registered read data (data bits of the word)
//   parity_err  out  1           registered parity error flag
//                                (PARITY_CHECK_EN only)
// -----------------------------------------------------------------------------
module my_mem #(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 2 ** ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  write,
    input  logic                  read,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out
`ifdef PARITY_CHECK_EN
    ,
    output logic                  parity_err
`endif
);

    // Storage: bit DATA_WIDTH holds the parity bit. The array has no reset,
    // so its contents survive rst.
    logic [DATA_WIDTH:0] mem [DEPTH];

    // Word to store: the parity bit makes the total count of ones odd.
    logic [DATA_WIDTH:0] wr_word;

    always_comb begin
        wr_word = {~^data_in, data_in};
    end

    // Writes are blocked during reset.
    always_ff @(posedge clk) begin
        if (!rst && write) begin
            mem[address] <= wr_word;
        end
    end

    // Registered read. The write in the same cycle uses a nonblocking update,
    // so a read and write at the same address returns the old word.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_out <= '0;
        end else if (read) begin
            data_out <= mem[address][DATA_WIDTH-1:0];
        end
    end

`ifdef PARITY_CHECK_EN
    // Even parity over the whole stored word marks the word as corrupt.
    // The flag updates with data_out and holds its value between reads.
    always_ff @(posedge clk) begin
        if (rst) begin
            parity_err <= 1'b0;
        end else if (read) begin
            parity_err <= ~^mem[address];
        end
    end
`endif

endmodule

// File: tb/tb_my_mem.sv
// -----------------------------------------------------------------------------
// tb_my_mem: scoreboard testbench for my_mem.
//
// The driver issues accesses and updates a reference array of stored words.
// For every read, it pushes the expected response into a queue. A separate
// monitor runs on each falling edge and checks data_out:
//   - after a reset cycle, data_out must be 0;
//   - after a read cycle, data_out must match the value popped from the queue;
//   - otherwise, data_out must hold its previous value.
//
// Defining PARITY_CHECK_EN also checks parity_err. In that build, a backdoor
// write stores a word with the wrong parity bit.
// -----------------------------------------------------------------------------
module tb_my_mem;

    logic        clk = 1'b0;
    logic        rst;
    logic        write;
    logic        read;
    logic [15:0] address;
    logic [7:0]  data_in;
    logic [7:0]  data_out;
`ifdef PARITY_CHECK_EN
    logic        parity_err;
`endif

    always #5 clk = ~clk;

    my_mem #(
        .ADDR_WIDTH (16),
        .DATA_WIDTH (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .write      (write),
        .read       (read),
        .address    (address),
        .data_in    (data_in),
        .data_out   (data_out)
`ifdef PARITY_CHECK_EN
        ,
        .parity_err (parity_err)
`endif
    );

    typedef struct {
        logic [7:0] d;
        logic       p;
    } exp_t;

    exp_t       sb[$];
    logic [8:0] ref_mem [65536];   // reference words: {parity bit, data}
    int         n_checks = 0;
    int         n_fail   = 0;

    // Parity bit that gives an odd total count of ones across the 9 bits.
    function automatic logic par_bit(input logic [7:0] d);
        return ($countones(d) % 2) == 0;
    endfunction

    // A stored word is corrupt when its 9 bits hold an even count of ones.
    function automatic logic word_bad(input logic [8:0] w);
        return ($countones(w) % 2) == 0;
    endfunction

    // ---------------------------------------------------------------- monitor
    logic s_rst = 1'b0;
    logic s_rd  = 1'b0;
    logic armed = 1'b0;
    exp_t last;

    always @(posedge clk) begin
        s_rst = rst;
        s_rd  = read;
    end

    always @(negedge clk) begin
        if (s_rst) begin
            armed = 1'b1;
            last  = '{d: 8'h00, p: 1'b0};
        end else if (armed && s_rd) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_underflow: read response with empty queue, data_out=%h", data_out);
            end else begin
                last = sb.pop_front();
            end
        end
        if (armed) begin
            n_checks++;
            if (data_out !== last.d) begin
                n_fail++;
                $display("FAIL data_out @%0t: got %h required %h", $time, data_out, last.d);
            end
`ifdef PARITY_CHECK_EN
            n_checks++;
            if (parity_err !== last.p) begin
                n_fail++;
                $display("FAIL parity_err @%0t: got %b required %b", $time, parity_err, last.p);
            end
`endif
        end
    end

    // ----------------------------------------------------------------- driver
    task automatic cycle(input logic w, input logic r,
                         input logic [15:0] a, input logic [7:0] d);
        write   = w;
        read    = r;
        address = a;
        data_in = d;
        if (!rst) begin
            // Read-before-write: capture the expected read before updating.
            if (r) sb.push_back('{d: ref_mem[a][7:0], p: word_bad(ref_mem[a])});
            if (w) ref_mem[a] = {par_bit(d), d};
        end
        @(posedge clk);
        #2;
    endtask

    logic [15:0] addrs [100];
    logic [7:0]  datas [100];

    initial begin
        for (int i = 0; i < 65536; i++) ref_mem[i] = 9'h000;
        rst = 1'b1; write = 1'b0; read = 1'b0; address = '0; data_in = '0;
        @(posedge clk);
        #2;
        rst = 1'b0;

        // Boundary addresses with both patterns.
        cycle(1'b1, 1'b0, 16'h0000, 8'hA5);
        cycle(1'b1, 1'b0, 16'hFFFF, 8'h5A);
        cycle(1'b0, 1'b1, 16'h0000, 8'h00);
        cycle(1'b0, 1'b1, 16'hFFFF, 8'h00);
        cycle(1'b1, 1'b0, 16'h0000, 8'h5A);
        cycle(1'b1, 1'b0, 16'hFFFF, 8'hA5);
        cycle(1'b0, 1'b1, 16'h0000, 8'h00);
        cycle(1'b0, 1'b1, 16'hFFFF, 8'h00);

        // Write 100 random pairs, including repeated addresses, then read them back.
        for (int i = 0; i < 100; i++) begin
            addrs[i] = (i % 10 == 9) ? addrs[i-3] : 16'($urandom);
            datas[i] = 8'($urandom);
            cycle(1'b1, 1'b0, addrs[i], datas[i]);
        end
        for (int i = 0; i < 100; i++) cycle(1'b0, 1'b1, addrs[i], 8'h00);

        // Read during write returns the old word.
        cycle(1'b1, 1'b0, 16'h1234, 8'h11);
        cycle(1'b1, 1'b1, 16'h1234, 8'h22);
        cycle(1'b0, 1'b1, 16'h1234, 8'h00);

        // Hold: data_out keeps 3C while read is low.
        cycle(1'b1, 1'b0, 16'h4000, 8'h3C);
        cycle(1'b0, 1'b1, 16'h4000, 8'h00);
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 16'($urandom), 8'($urandom));

        // Reset clears data_out, ignores read/write, and keeps the array.
        cycle(1'b1, 1'b0, 16'h0005, 8'h33);
        cycle(1'b0, 1'b1, 16'h0005, 8'h00);
        rst = 1'b1;
        cycle(1'b1, 1'b1, 16'h0005, 8'h77);
        rst = 1'b0;
        cycle(1'b0, 1'b0, 16'h0005, 8'h00);
        cycle(1'b0, 1'b1, 16'h0005, 8'h00);

        // Random mixed traffic over a small address window.
        for (int i = 0; i < 300; i++)
            cycle(1'($urandom), 1'($urandom), 16'($urandom_range(15)), 8'($urandom));

`ifdef PARITY_CHECK_EN
        cycle(1'b1, 1'b0, 16'h0077, 8'h00);
        cycle(1'b0, 1'b1, 16'h0077, 8'h00);
        // Backdoor: store 0x00 with its parity bit cleared (correct value is 1).
        dut.mem[16'h0077] = 9'h000;
        ref_mem[16'h0077] = 9'h000;
        cycle(1'b0, 1'b1, 16'h0077, 8'h00);
        cycle(1'b0, 1'b0, 16'h0000, 8'h00);
        cycle(1'b1, 1'b0, 16'h0077, 8'h00);
        cycle(1'b0, 1'b1, 16'h0077, 8'h00);
`endif

        // Drain: allow a bounded number of cycles for outstanding responses.
        for (int i = 0; i < 20 && sb.size() != 0; i++) cycle(1'b0, 1'b0, 16'h0000, 8'h00);
        cycle(1'b0, 1'b0, 16'h0000, 8'h00);
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: %0d responses outstanding, required 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
